// File: rtl/byte_unstripe_pkg.sv
// Shared definitions for the N-lane byte un-striper: FSM encoding, default idle
// symbol and a constant-safe clog2 helper.
package byte_unstripe_pkg;

  typedef enum logic [0:0] {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h7C;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_unstripe_n_lane_fifo.sv
// Per-lane skew FIFO: combinational head, occupancy counter one bit wider than the
// pointers, and a one-cycle pulse when a push is dropped because the FIFO is full.
module lane_fifo
  import byte_unstripe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf_pulse
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en_s;
  logic             rd_en_s;

  assign empty     = (count_q == (AW+1)'(0));
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign dout      = mem_q[rd_ptr_q];
  // A full FIFO still accepts a push when the same edge pops it.
  assign wr_en_s   = push & (~full | pop);
  assign rd_en_s   = pop & ~empty;
  assign ovf_pulse = push & full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_2f) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/byte_unstripe_n.sv
// N-lane byte un-striper: per-lane skew FIFOs drained round-robin into one byte
// stream. Optional BYTE_UNSTRIPE_DROP_IDLE_EN discards idle symbols while aligning.
module byte_unstripe_n
  import byte_unstripe_pkg::*;
#(
  parameter int               LANES     = 2,
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] IDLE_BYTE = WIDTH'(IDLE_BYTE_DEFAULT)
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] lane_data,
  input  logic [LANES-1:0]       lane_valid,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic                   aligned,
  output logic [LANES-1:0]       overflow
);

  localparam int RR_W = clog2(LANES);

  state_e           state_q, state_d;
  logic [RR_W-1:0]  rr_q, rr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic [LANES-1:0] overflow_q, overflow_d;

  logic [LANES-1:0] push_s;
  logic [LANES-1:0] pop_s;
  logic [LANES-1:0] empty_s;
  logic [LANES-1:0] unused_full_s;
  logic [LANES-1:0] ovf_s;
  logic [WIDTH-1:0] lane_dout_s [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef BYTE_UNSTRIPE_DROP_IDLE_EN
    // Leading idle fill is skipped only while aligning; in RUN idles are payload.
    assign push_s[g] = lane_valid[g] &
                       ~((state_q == ST_ALIGN) && (lane_data[g*WIDTH +: WIDTH] == IDLE_BYTE));
`else
    assign push_s[g] = lane_valid[g];
`endif

    lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_2f    (clk_2f),
      .reset     (reset),
      .push      (push_s[g]),
      .pop       (pop_s[g]),
      .din       (lane_data[g*WIDTH +: WIDTH]),
      .dout      (lane_dout_s[g]),
      .empty     (empty_s[g]),
      .full      (unused_full_s[g]),
      .ovf_pulse (ovf_s[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    overflow_d  = overflow_q | ovf_s;
    pop_s       = {LANES{1'b0}};
    case (state_q)
      ST_ALIGN: begin
        rr_d = RR_W'(0);
        if (empty_s == {LANES{1'b0}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_RUN: begin
        // An empty current lane stalls the pointer so byte order is preserved.
        if (!empty_s[rr_q]) begin
          pop_s[rr_q] = 1'b1;
          data_out_d  = lane_dout_s[rr_q];
          valid_out_d = 1'b1;
          if (rr_q == RR_W'(LANES - 1)) begin
            rr_d = RR_W'(0);
          end else begin
            rr_d = rr_q + RR_W'(1);
          end
        end else begin
          rr_d = rr_q;
        end
      end
      default: begin
        state_d = ST_ALIGN;
        rr_d    = RR_W'(0);
      end
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      state_q     <= ST_ALIGN;
      rr_q        <= RR_W'(0);
      data_out_q  <= WIDTH'(0);
      valid_out_q <= 1'b0;
      overflow_q  <= {LANES{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;
  assign aligned   = (state_q == ST_RUN);

endmodule

// File: tb/tb_byte_unstripe_n.sv
// Directed self-checking bench for byte_unstripe_n (2-lane and 4-lane instances);
// expectations follow BYTE_UNSTRIPE_DROP_IDLE_EN when it is defined.
module tb_byte_unstripe_n;

  logic clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  logic        reset;
  logic [15:0] d2;
  logic [1:0]  v2;
  logic [7:0]  o2;
  logic        ov2;
  logic        al2;
  logic [1:0]  of2;
  logic [31:0] d4;
  logic [3:0]  v4;
  logic [7:0]  o4;
  logic        ov4;
  logic        al4;
  logic [3:0]  of4;

  int errors = 0;
  int checks = 0;

  byte_unstripe_n #(.LANES(2), .WIDTH(8), .DEPTH(4), .IDLE_BYTE(8'h7C)) u_dut2 (
    .clk_2f(clk_2f), .reset(reset), .lane_data(d2), .lane_valid(v2),
    .data_out(o2), .valid_out(ov2), .aligned(al2), .overflow(of2)
  );

  byte_unstripe_n #(.LANES(4), .WIDTH(8), .DEPTH(4), .IDLE_BYTE(8'h7C)) u_dut4 (
    .clk_2f(clk_2f), .reset(reset), .lane_data(d4), .lane_valid(v4),
    .data_out(o4), .valid_out(ov4), .aligned(al4), .overflow(of4)
  );

  task automatic step2(input logic [1:0] v, input logic [7:0] b0, input logic [7:0] b1);
    v2 = v;
    d2 = {b1, b0};
    v4 = 4'b0000;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic step4(input logic [3:0] v, input logic [31:0] d);
    v4 = v;
    d4 = d;
    v2 = 2'b00;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    v2 = 2'b00;
    v4 = 4'b0000;
    @(posedge clk_2f);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    v2 = 2'b11;
    d2 = 16'hB0A0;
    v4 = 4'b1111;
    d4 = 32'h13121110;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_2f);
      #1;
      checks++;
      if ({o2, ov2, al2, of2} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got data=%h v=%b al=%b ovf=%b exp all zero", k, o2, ov2, al2, of2);
      end
      checks++;
      if ({o4, ov4, al4, of4} !== 14'h0000) begin
        errors++;
        $display("FAIL reset_outputs4 cyc=%0d got data=%h v=%b al=%b ovf=%b exp all zero", k, o4, ov4, al4, of4);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step2(2'b00, 8'h00, 8'h00);
      checks++;
      if (al2 !== 1'b0 || ov2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_writes cyc=%0d got al=%b v=%b exp al=0 v=0", k, al2, ov2);
      end
    end
  endtask

  task automatic test_skew();
    logic [1:0] vin [7];
    logic [7:0] b0  [7];
    logic [7:0] b1  [7];
    logic       eal [7];
    logic       ev  [7];
    logic [7:0] ed  [7];
    vin = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    b0  = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b1  = '{8'h00, 8'h00, 8'hB0, 8'h00, 8'h00, 8'h00, 8'h00};
    eal = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ev  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ed  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA0, 8'hB0, 8'hB0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step2(vin[k], b0[k], b1[k]);
      checks++;
      if (al2 !== eal[k] || ov2 !== ev[k] || o2 !== ed[k]) begin
        errors++;
        $display("FAIL skew cyc=%0d got al=%b v=%b data=%h exp al=%b v=%b data=%h",
                 k, al2, ov2, o2, eal[k], ev[k], ed[k]);
      end
    end
    checks++;
    if (of2 !== 2'b00) begin
      errors++;
      $display("FAIL skew_overflow got=%b exp=00", of2);
    end
  endtask

  task automatic test_lanes4();
    logic [3:0] vin;
    logic       exp_v;
    logic [7:0] exp_d;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k < 4) vin = 4'b1111;
      else if (k < 6) vin = 4'b1100;
      else vin = 4'b0000;
      step4(vin, 32'h13121110);
      exp_v = (k >= 2) && (k <= 17);
      exp_d = 8'h10 + 8'((k - 2) % 4);
      checks++;
      if (ov4 !== exp_v || (exp_v && o4 !== exp_d)) begin
        errors++;
        $display("FAIL lanes4_stream cyc=%0d got v=%b data=%h exp v=%b data=%h", k, ov4, o4, exp_v, exp_d);
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (of4 !== ((k == 3) ? 4'b0000 : 4'b1000)) begin
          errors++;
          $display("FAIL lanes4_ovf_early cyc=%0d got=%b exp=%b", k, of4, (k == 3) ? 4'b0000 : 4'b1000);
        end
      end
    end
    checks++;
    if (of4 !== 4'b1100) begin
      errors++;
      $display("FAIL lanes4_overflow got=%b exp=1100", of4);
    end
  endtask

  task automatic test_overflow2();
    logic [7:0] ed [17];
    logic       ev;
    ed = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h01, 8'hC1, 8'h02, 8'hC2, 8'h03, 8'hC3, 8'h04, 8'hC4, 8'hC4};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step2(2'b01, 8'(k + 1), 8'h00);
      checks++;
      if (of2 !== ((k >= 4) ? 2'b01 : 2'b00) || al2 !== 1'b0) begin
        errors++;
        $display("FAIL ovf2_fill cyc=%0d got ovf=%b al=%b exp ovf=%b al=0", k, of2, al2, (k >= 4) ? 2'b01 : 2'b00);
      end
    end
    for (int k = 6; k < 17; k++) begin
      if (k < 10) step2(2'b10, 8'h00, 8'hC1 + 8'(k - 6));
      else step2(2'b00, 8'h00, 8'h00);
      ev = (k >= 8) && (k <= 15);
      checks++;
      if (ov2 !== ev || o2 !== ed[k] || al2 !== (k >= 7)) begin
        errors++;
        $display("FAIL ovf2_drain cyc=%0d got v=%b data=%h al=%b exp v=%b data=%h al=%b",
                 k, ov2, o2, al2, ev, ed[k], (k >= 7));
      end
    end
    checks++;
    if (of2 !== 2'b01) begin
      errors++;
      $display("FAIL ovf2_sticky got=%b exp=01", of2);
    end
  endtask

  task automatic test_stall_reset();
    logic [1:0] vin [10];
    logic [7:0] b0  [10];
    logic [7:0] b1  [10];
    logic       ev  [10];
    logic [7:0] ed  [10];
    vin = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11};
    b0  = '{8'hD0, 8'hD1, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hD3, 8'hD4};
    b1  = '{8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE1, 8'hE2, 8'hE3};
    ev  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ed  = '{8'h00, 8'h00, 8'hD0, 8'hE0, 8'hD1, 8'hD1, 8'hD1, 8'hD1, 8'hE1, 8'hD2};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step2(vin[k], b0[k], b1[k]);
      checks++;
      if (ov2 !== ev[k] || o2 !== ed[k] || al2 !== (k >= 1)) begin
        errors++;
        $display("FAIL stall cyc=%0d got v=%b data=%h al=%b exp v=%b data=%h al=%b",
                 k, ov2, o2, al2, ev[k], ed[k], (k >= 1));
      end
    end
    do_reset();
    checks++;
    if ({o2, ov2, al2, of2} !== 12'h000) begin
      errors++;
      $display("FAIL midreset got data=%h v=%b al=%b ovf=%b exp all zero", o2, ov2, al2, of2);
    end
    for (int k = 0; k < 3; k++) begin
      step2(2'b00, 8'h00, 8'h00);
      checks++;
      if (al2 !== 1'b0) begin
        errors++;
        $display("FAIL midreset_flushed cyc=%0d got al=%b exp=0", k, al2);
      end
    end
    step2(2'b11, 8'hF0, 8'hF1);
    step2(2'b00, 8'h00, 8'h00);
    step2(2'b00, 8'h00, 8'h00);
    checks++;
    if (ov2 !== 1'b1 || o2 !== 8'hF0) begin
      errors++;
      $display("FAIL midreset_resume0 got v=%b data=%h exp v=1 data=f0", ov2, o2);
    end
    step2(2'b00, 8'h00, 8'h00);
    checks++;
    if (ov2 !== 1'b1 || o2 !== 8'hF1) begin
      errors++;
      $display("FAIL midreset_resume1 got v=%b data=%h exp v=1 data=f1", ov2, o2);
    end
  endtask

  task automatic test_idle();
    logic [1:0] vin [8];
    logic [7:0] b0  [8];
    logic [7:0] b1  [8];
    logic       ev  [8];
    logic [7:0] ed  [8];
    vin = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    b0  = '{8'h7C, 8'h7C, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b1  = '{8'h7C, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef BYTE_UNSTRIPE_DROP_IDLE_EN
    ev  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ed  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hB1, 8'hB1, 8'hB1};
`else
    ev  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ed  = '{8'h00, 8'h00, 8'h7C, 8'h7C, 8'h7C, 8'hB1, 8'hA1, 8'hA1};
`endif
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step2(vin[k], b0[k], b1[k]);
      checks++;
      if (ov2 !== ev[k] || o2 !== ed[k]) begin
        errors++;
        $display("FAIL idle cyc=%0d got v=%b data=%h exp v=%b data=%h", k, ov2, o2, ev[k], ed[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    v2 = 2'b00;
    d2 = 16'h0000;
    v4 = 4'b0000;
    d4 = 32'h00000000;
    test_reset();
    test_skew();
    test_lanes4();
    test_overflow2();
    test_stall_reset();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
